// File: rtl/uart_load_pkg.sv
// rtl/uart_load_pkg.sv - shared types and constants for the UART download sequencer
package uart_load_pkg;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_SYNC = 3'd1,
        ST_LOAD = 3'd2,
        ST_DONE = 3'd3,
        ST_ERR  = 3'd4
    } state_t;

    localparam logic [7:0] SYNC_BYTE_DEFAULT = 8'hAA;

endpackage

// File: rtl/byte_packer.sv
// rtl/byte_packer.sv - packs received bytes big-endian into 32-bit memory words
module byte_packer #(
    parameter int ADDR_W = 10
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              clear,
    input  logic              byte_valid,
    input  logic [7:0]        byte_data,
    input  logic              last,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic              final_write
);

    logic [31:0] shift_q;
    logic [1:0]  lane_q;
    logic        last_q;
    logic [31:0] shifted;
    logic [31:0] packed_word;
    logic        word_done;

    // The shift register always appends at the bottom; a short final word is
    // left-aligned by shifting out the lanes that never arrived.
    assign shifted     = {shift_q[23:0], byte_data};
    assign packed_word = shifted << {2'd3 - lane_q, 3'b000};
    assign word_done   = byte_valid && ((lane_q == 2'd3) || last);
    assign final_write = mem_we && last_q;

    // Byte lane tracking, word capture, one-cycle write strobe and address advance
    always_ff @(posedge clk) begin
        if (!rstn) begin
            shift_q   <= '0;
            lane_q    <= '0;
            last_q    <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
        end else if (clear) begin
            shift_q   <= '0;
            lane_q    <= '0;
            last_q    <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
        end else begin
            mem_we <= word_done;
            if (byte_valid) begin
                shift_q <= shifted;
                lane_q  <= lane_q + 2'd1;
            end
            if (word_done) begin
                mem_wdata <= packed_word;
                last_q    <= last;
            end
            if (mem_we) begin
                mem_addr <= mem_addr + ADDR_W'(1);
            end
        end
    end

endmodule

// File: rtl/uart_load_ctrl.sv
// rtl/uart_load_ctrl.sv - sync handshake, byte download into data memory and uart_tx sharing
module uart_load_ctrl
    import uart_load_pkg::*;
#(
    parameter int         NBYTES    = 1300,
    parameter int         ADDR_W    = 10,
    parameter logic [7:0] SYNC_BYTE = SYNC_BYTE_DEFAULT
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              start,
    input  logic [7:0]        rx_data,
    input  logic              rx_ready,
    input  logic              rx_ferr,
    output logic [7:0]        tx_data,
    output logic              tx_start,
    input  logic              tx_busy,
    input  logic [7:0]        cpu_tx_data,
    input  logic              cpu_tx_req,
    output logic              cpu_tx_ack,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic              busy,
    output logic              done,
    output logic              err
);

    localparam int CNT_W = $clog2(NBYTES + 1);

    state_t           state_q;
    state_t           state_d;
    logic             guard_q;
    logic [CNT_W-1:0] count_q;
    logic             byte_valid;
    logic             last_byte;
    logic             pk_clear;
    logic             final_write;

    // Bytes beyond NBYTES (e.g. during the final write cycle) are dropped
    assign byte_valid = (state_q == ST_LOAD) && rx_ready && !rx_ferr
                        && (count_q != CNT_W'(NBYTES));
    assign last_byte  = (count_q == CNT_W'(NBYTES - 1));

    assign busy = (state_q == ST_SYNC) || (state_q == ST_LOAD);
    assign done = (state_q == ST_DONE);
    assign err  = (state_q == ST_ERR);

    byte_packer #(.ADDR_W(ADDR_W)) u_packer (
        .clk         (clk),
        .rstn        (rstn),
        .clear       (pk_clear),
        .byte_valid  (byte_valid),
        .byte_data   (rx_data),
        .last        (last_byte),
        .mem_we      (mem_we),
        .mem_addr    (mem_addr),
        .mem_wdata   (mem_wdata),
        .final_write (final_write)
    );

    // State, byte count and the post-start guard that covers tx_busy's one-cycle lag
    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q <= ST_IDLE;
            guard_q <= 1'b0;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            guard_q <= tx_start;
            if (pk_clear) begin
                count_q <= '0;
            end else if (byte_valid) begin
                count_q <= count_q + CNT_W'(1);
            end
        end
    end

    // Next state plus uart_tx ownership: sync byte in SYNC, CPU bytes in DONE
    always_comb begin
        state_d    = state_q;
        tx_start   = 1'b0;
        tx_data    = 8'h00;
        cpu_tx_ack = 1'b0;
        pk_clear   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start) state_d = ST_SYNC;
            end
            ST_SYNC: begin
                if (!tx_busy && !guard_q) begin
                    tx_start = 1'b1;
                    tx_data  = SYNC_BYTE;
                    pk_clear = 1'b1;
                    state_d  = ST_LOAD;
                end
            end
            ST_LOAD: begin
                if (final_write) begin
                    state_d = ST_DONE;
                end else if (rx_ready && rx_ferr) begin
                    state_d = ST_ERR;
                end
            end
            ST_DONE: begin
                if (start) begin
                    state_d = ST_SYNC;
                end else if (cpu_tx_req && !tx_busy && !guard_q) begin
                    tx_start   = 1'b1;
                    tx_data    = cpu_tx_data;
                    cpu_tx_ack = 1'b1;
                end
            end
            ST_ERR: begin
                if (start) state_d = ST_SYNC;
            end
            default: state_d = ST_IDLE;
        endcase
    end

endmodule

// File: tb/tb_uart_load_ctrl.sv
// tb/tb_uart_load_ctrl.sv - randomized self-checking bench for uart_load_ctrl
module tb_uart_load_ctrl;

    localparam int NB = 10;
    localparam int AW = 4;

    logic          clk = 1'b0;
    logic          rstn = 1'b0;
    logic          start = 1'b0;
    logic [7:0]    rx_data = 8'h00;
    logic          rx_ready = 1'b0;
    logic          rx_ferr = 1'b0;
    logic [7:0]    tx_data;
    logic          tx_start;
    logic          tx_busy;
    logic [7:0]    cpu_tx_data = 8'h00;
    logic          cpu_tx_req = 1'b0;
    logic          cpu_tx_ack;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [31:0]   mem_wdata;
    logic          busy;
    logic          done;
    logic          err;

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int last_tx = -100;
    int ack_cnt = 0;
    int busy_cnt = 0;
    logic [7:0] host_bytes [NB];

    uart_load_ctrl #(.NBYTES(NB), .ADDR_W(AW), .SYNC_BYTE(8'hAA)) dut (
        .clk         (clk),
        .rstn        (rstn),
        .start       (start),
        .rx_data     (rx_data),
        .rx_ready    (rx_ready),
        .rx_ferr     (rx_ferr),
        .tx_data     (tx_data),
        .tx_start    (tx_start),
        .tx_busy     (tx_busy),
        .cpu_tx_data (cpu_tx_data),
        .cpu_tx_req  (cpu_tx_req),
        .cpu_tx_ack  (cpu_tx_ack),
        .mem_we      (mem_we),
        .mem_addr    (mem_addr),
        .mem_wdata   (mem_wdata),
        .busy        (busy),
        .done        (done),
        .err         (err)
    );

    always #5 clk = ~clk;

    // uart_tx stand-in: busy rises the cycle after tx_start and lasts a random time
    assign tx_busy = (busy_cnt != 0);
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (tx_start) busy_cnt <= $urandom_range(3, 10);
        else if (busy_cnt != 0) busy_cnt <= busy_cnt - 1;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Reference word: bytes 4w..4w+3 big-endian, missing bytes read as zero
    function automatic logic [31:0] model_word(input int w);
        logic [31:0] r;
        r = 32'h0;
        for (int j = 0; j < 4; j++) begin
            if (4 * w + j < NB) r[31 - 8 * j -: 8] = host_bytes[4 * w + j];
        end
        return r;
    endfunction

    // tx rules that hold at all times
    always @(negedge clk) begin
        if (tx_start) begin
            check("tx_gap", 32'(cyc - last_tx >= 2), 32'd1);
            check("tx_while_busy", 32'(tx_busy), 32'd0);
            last_tx = cyc;
        end
        if (cpu_tx_ack) begin
            ack_cnt++;
            check("ack_only_in_done", 32'(done), 32'd1);
            check("ack_with_tx_start", 32'(tx_start), 32'd1);
            check("ack_tx_data", 32'(tx_data), 32'(cpu_tx_data));
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b, input logic fe);
        rx_data  = b;
        rx_ferr  = fe;
        rx_ready = 1'b1;
        tick();
        rx_ready = 1'b0;
        rx_ferr  = 1'b0;
        rx_data  = 8'($urandom);
    endtask

    task automatic start_pulse();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic wait_sync();
        for (int n = 0; n < 60; n++) begin
            @(negedge clk);
            if (tx_start) break;
        end
        check("sync_tx_start", 32'(tx_start), 32'd1);
        check("sync_tx_data", 32'(tx_data), 32'h0000_00AA);
        check("sync_err_clear", 32'(err), 32'd0);
        check("sync_busy", 32'(busy), 32'd1);
        tick();
    endtask

    // Download NB random bytes; fe_at >= 0 injects a framing error on that byte
    task automatic load_bytes(input int fe_at);
        int  acks0;
        logic complete;
        acks0 = ack_cnt;
        for (int i = 0; i < NB; i++) host_bytes[i] = 8'($urandom);
        for (int i = 0; i < NB; i++) begin
            cpu_tx_req  = (i < NB - 1) ? 1'($urandom_range(0, 1)) : 1'b0;
            cpu_tx_data = 8'($urandom);
            if (i == fe_at) begin
                send_byte(host_bytes[i], 1'b1);
                @(negedge clk);
                check("ferr_err", 32'(err), 32'd1);
                check("ferr_no_we", 32'(mem_we), 32'd0);
                tick();
                for (int k = 0; k < 4; k++) begin
                    send_byte(8'($urandom), 1'b0);
                    @(negedge clk);
                    check("err_ignore_we", 32'(mem_we), 32'd0);
                    check("err_sticky", 32'(err), 32'd1);
                    tick();
                end
                cpu_tx_req = 1'b0;
                check("no_ack_in_load", 32'(ack_cnt), 32'(acks0));
                return;
            end
            send_byte(host_bytes[i], 1'b0);
            @(negedge clk);
            complete = (i % 4 == 3) || (i == NB - 1);
            check("we", 32'(mem_we), 32'(complete));
            if (complete) begin
                check("addr", 32'(mem_addr), 32'(i / 4));
                check("wdata", mem_wdata, model_word(i / 4));
            end
            if (i == NB - 1) begin
                @(negedge clk);
                check("done", 32'(done), 32'd1);
                check("busy_in_done", 32'(busy), 32'd0);
                check("we_after_done", 32'(mem_we), 32'd0);
            end
            repeat ($urandom_range(1, 3)) tick();
        end
        cpu_tx_req = 1'b0;
        check("no_ack_in_load", 32'(ack_cnt), 32'(acks0));
    endtask

    // CPU bytes through the arbiter while in DONE
    task automatic arb(input int nbytes);
        int  acks0;
        logic got;
        acks0 = ack_cnt;
        for (int b = 0; b < nbytes; b++) begin
            cpu_tx_data = (b == 0) ? 8'h41 : (b == 1) ? 8'h42 : 8'($urandom);
            cpu_tx_req  = 1'b1;
            got = 1'b0;
            for (int n = 0; n < 80; n++) begin
                @(negedge clk);
                if (cpu_tx_ack) begin
                    got = 1'b1;
                    break;
                end
            end
            check("arb_ack_seen", 32'(got), 32'd1);
            tick();
            cpu_tx_req = 1'b0;
            repeat ($urandom_range(0, 3)) tick();
        end
        check("arb_ack_count", 32'(ack_cnt - acks0), 32'(nbytes));
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_busy"}, 32'(busy), 32'd0);
        check({tag, "_done"}, 32'(done), 32'd0);
        check({tag, "_err"}, 32'(err), 32'd0);
        check({tag, "_tx_start"}, 32'(tx_start), 32'd0);
        check({tag, "_tx_data"}, 32'(tx_data), 32'd0);
        check({tag, "_ack"}, 32'(cpu_tx_ack), 32'd0);
        check({tag, "_we"}, 32'(mem_we), 32'd0);
        check({tag, "_addr"}, 32'(mem_addr), 32'd0);
        check({tag, "_wdata"}, mem_wdata, 32'd0);
    endtask

    initial begin
        repeat (3) tick();
        @(negedge clk);
        check_reset_outputs("reset");
        rstn = 1'b1;
        tick();

        // rx_ready while idle is ignored
        send_byte(8'h5A, 1'b0);
        @(negedge clk);
        check("idle_ignore_we", 32'(mem_we), 32'd0);
        tick();

        start_pulse();
        wait_sync();
        load_bytes(-1);
        arb(2);

        // start and CPU request together in DONE: start wins
        while (tx_busy) tick();
        repeat (2) tick();
        start       = 1'b1;
        cpu_tx_req  = 1'b1;
        cpu_tx_data = 8'h77;
        @(negedge clk);
        check("start_wins_ack", 32'(cpu_tx_ack), 32'd0);
        check("start_wins_tx", 32'(tx_start), 32'd0);
        tick();
        start = 1'b0;
        wait_sync();
        cpu_tx_req = 1'b0;
        load_bytes(2);

        start_pulse();
        wait_sync();
        load_bytes(-1);

        for (int r = 0; r < 5; r++) begin
            start_pulse();
            wait_sync();
            load_bytes(($urandom_range(0, 2) == 0) ? int'($urandom_range(0, NB - 1)) : -1);
            if (done) arb(int'($urandom_range(1, 3)));
        end

        // reset part-way through a load
        start_pulse();
        wait_sync();
        for (int i = 0; i < 3; i++) begin
            send_byte(8'($urandom), 1'b0);
            tick();
        end
        rstn = 1'b0;
        tick();
        @(negedge clk);
        check_reset_outputs("midrst");
        tick();
        rstn = 1'b1;
        for (int k = 0; k < 5; k++) begin
            send_byte(8'($urandom), 1'b0);
            @(negedge clk);
            check("post_rst_we", 32'(mem_we), 32'd0);
            check("post_rst_busy", 32'(busy), 32'd0);
            tick();
        end
        start_pulse();
        wait_sync();
        load_bytes(-1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1);
    end

endmodule

// File: doc/uart_load_ctrl.md
Name: uart_load_ctrl

Overview:
- CPU-side sequencer for the host-to-core data download over the shared UART pair (uart_tx / uart_rx).
- On start, sends the sync byte (0xAA) to the host, then receives exactly NBYTES bytes, packs them into 32-bit words and writes them to data memory.
- After the load completes, arbitrates uart_tx so the CPU can send output bytes through it.
- Sits in top between the UART instances and the core/data memory.

Parameters:
- NBYTES, 1300, number of bytes to receive per load (>=1).
- ADDR_W, 10, word-address width of mem_addr; must satisfy 2^ADDR_W >= ceil(NBYTES/4).
- SYNC_BYTE, 8'hAA, byte sent to the host to request data.

Ports:
- clk  in  1  system clock.
- rstn  in  1  synchronous active-low reset.
- start  in  1  one-cycle pulse that begins a load; ignored unless state is IDLE, DONE or ERR.
- rx_data  in  8  byte from uart_rx.
- rx_ready  in  1  one-cycle pulse from uart_rx; rx_data is valid in that cycle.
- rx_ferr  in  1  framing error from uart_rx, sampled with rx_ready.
- tx_data  out  8  byte to uart_tx.
- tx_start  out  1  one-cycle start pulse to uart_tx.
- tx_busy  in  1  uart_tx busy; rises 1 cycle after tx_start.
- cpu_tx_data  in  8  CPU output byte.
- cpu_tx_req  in  1  CPU send request; held until acknowledged.
- cpu_tx_ack  out  1  one-cycle pulse; CPU byte accepted.
- mem_we  out  1  word write strobe.
- mem_addr  out  ADDR_W  word address.
- mem_wdata  out  32  packed word.
- busy  out  1  high in SYNC and LOAD.
- done  out  1  high in DONE.
- err  out  1  high in ERR.

Behaviour:
- Reset: state IDLE; tx_start, cpu_tx_ack, mem_we, busy, done, err = 0; tx_data, mem_addr, mem_wdata, byte count and guard = 0.
- States and transitions:
  - IDLE: on start, go to SYNC.
  - SYNC: when ~tx_busy and guard==0, pulse tx_start for 1 cycle with tx_data=SYNC_BYTE, clear count/address/shift register, then go to LOAD.
  - LOAD: each rx_ready with rx_ferr==0 shifts rx_data into the shift register (big-endian: first byte lands in bits 31:24) and increments count.
  - LOAD, word write: in the cycle after the rx_ready that completes a word, assert mem_we for exactly 1 cycle with mem_wdata = packed word and mem_addr = current word index; mem_addr then increments. "Completes a word" means the 4th byte of a word, or byte number NBYTES.
  - LOAD, partial final word: bytes are left-aligned and the low bytes are zero (e.g. NBYTES=5: second word = {b4, 24'h0}).
  - LOAD, completion: on the final write cycle, go to DONE.
  - LOAD, framing error: rx_ready with rx_ferr==1 goes to ERR; no write for that byte, and any partial word is discarded.
  - DONE: done=1; start re-enters SYNC.
  - ERR: err=1 (sticky); start re-enters SYNC, which clears err.
- rx_ready outside LOAD is ignored (no count, no write).
- Arbiter, DONE state only: if cpu_tx_req & ~tx_busy & guard==0, then tx_start=1, tx_data=cpu_tx_data and cpu_tx_ack=1 in the same cycle. In any other state cpu_tx_ack stays 0.
- guard: set in the cycle after any tx_start and cleared in the next cycle. This blocks a second start while tx_busy has not yet risen, so there are never two tx_start pulses within 2 cycles.
- Simultaneous start and cpu_tx_req in DONE: start wins; the CPU request waits.
- Reset asserted mid-load: returns to the reset state in the next cycle; partially written memory is not cleaned.
- Count register width is $clog2(NBYTES+1); it never wraps because the load ends at NBYTES.

Decomposition:
- Package uart_load_pkg: state enum (IDLE, SYNC, LOAD, DONE, ERR) and the SYNC_BYTE default constant.
- Sub-module byte_packer: 32-bit shift register, 2-bit byte lane counter, flush-on-last output, and write strobe generation.
- The FSM and tx arbitration stay in uart_load_ctrl.

Test Plan:
- Basic load, NBYTES=8, host bytes 01..08: one tx_start with tx_data=AA. Required writes: mem_we at addr 0 with 32'h01020304, then addr 1 with 32'h05060708; done=1 in the cycle after the second write.
- Partial word, NBYTES=5, bytes 11..15: writes 32'h11121314 at addr 0, then 32'h15000000 at addr 1; then DONE.
- Framing error: rx_ferr=1 on the 3rd byte. Required: err=1, no mem_we after byte 2, later rx_ready ignored. Then start: sync byte resent, err=0, load succeeds.
- Arbitration: in DONE with cpu_tx_req held and bytes 41,42 presented in turn. Required: each accepted only when tx_busy=0; cpu_tx_ack asserted once per byte; tx_start pulses never closer than 2 cycles. Any request in LOAD gets no ack.
- Reset mid-load: rstn=0 after 3 of 8 bytes. Required: outputs return to reset values next cycle, and later rx_ready produces no mem_we until start.
- Full-size loopback with the CLK_PER_HALF_BIT=434 UARTs, NBYTES=1300: exactly 325 writes, last at addr 324; done=1.
